seq_unlock_cipher: RTL

Parametrised successor to the fixed 8-bit fake crypto stage in the cocotb exercise set. It sits inline on a byte/word stream and scrambles each valid beat with an XOR key, either static or rolling. It stops scrambling permanently when either of two things happens: a configurable cycle timeout expires, or a configurable unlock sequence is seen on the input. A `relock` input re-arms it, and a status port reports why it unlocked.

---
 rtl/seq_unlock_cipher.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_unlock_cipher.sv
// seq_unlock_cipher
//   Inline beat scrambler. Each valid beat is XORed with a key (static, or
//   rotated left after every scrambled beat) until the block unlocks. It
//   unlocks, and stays unlocked, on either of two events:
//     - a cycle timeout expires;
//     - an unlock sequence of distinct beats is seen.
//   Only rst or relock re-arm it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat qualifier
//   in_data    input beat [DATA_W]
//   relock     synchronous re-arm pulse (output registers untouched)
//   out_valid  in_valid delayed one cycle
//   out_data   processed beat, held while idle
//   status     00 scrambling, 01 unlocked by sequence, 10 unlocked by timeout
module seq_unlock_cipher #(
    parameter int                          DATA_W    = 8,
    parameter int                          SEQ_LEN   = 3,
    parameter logic [SEQ_LEN*DATA_W-1:0]   SEQ_VALUE = 24'h21F137,
    parameter int                          TIMEOUT   = 250,
    parameter logic [DATA_W-1:0]           KEY       = 8'hFF,
    parameter int                          MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              relock,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        status
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam int HW = SEQ_LEN * DATA_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(SEQ_LEN);

    typedef enum logic [1:0] {
        SCRAMBLE    = 2'b00,
        UNLOCK_SEQ  = 2'b01,
        UNLOCK_TIME = 2'b10
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     hist;      // oldest entry in the MSB word
    logic [FW-1:0]     fill;
    logic [DATA_W-1:0] key;

    logic [DATA_W-1:0] newest;
    logic [HW-1:0]     hist_next;
    logic              push;
    logic              seq_hit;

    assign newest = hist[DATA_W-1:0];

    generate
        if (SEQ_LEN == 1) begin : g_hist1
            assign hist_next = in_data;
        end else begin : g_histn
            assign hist_next = {hist[HW-DATA_W-1:0], in_data};
        end
    endgenerate

    // Repeated beats collapse into one history entry.
    assign push = in_valid && ((fill == '0) || (in_data != newest));

    // The full sequence is recognised only when a further, different beat
    // arrives after it; that beat is still scrambled.
    assign seq_hit = (state == SCRAMBLE) && in_valid && (fill == FILL_FULL) &&
                     (hist == SEQ_VALUE) && (in_data != newest);

    assign status = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCRAMBLE;
            cnt       <= '0;
            hist      <= '0;
            fill      <= '0;
            key       <= KEY;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // Output path always uses the current (pre-relock) state and key.
            out_valid <= in_valid;
            if (in_valid)
                out_data <= (state == SCRAMBLE) ? (in_data ^ key) : in_data;

            if (relock) begin
                state <= SCRAMBLE;
                cnt   <= '0;
                hist  <= '0;
                fill  <= '0;
                key   <= KEY;
            end else begin
                if (state == SCRAMBLE) begin
                    cnt <= cnt + CW'(1);
                    // Sequence unlock wins over a coincident timeout.
                    if (seq_hit)
                        state <= UNLOCK_SEQ;
                    else if (cnt == CNT_LAST)
                        state <= UNLOCK_TIME;
                    if (in_valid && (MODE == 1))
                        key <= (key << 1) | (key >> (DATA_W - 1));
                end
                if (push) begin
                    hist <= hist_next;
                    if (fill != FILL_FULL)
                        fill <= fill + FW'(1);
                end
            end
        end
    end

endmodule
